// File: rtl/sr_piso_pkg.sv
// Shared types and helpers for the sr_piso_serializer slice.
//   state_t      : FSM states (IDLE, SHIFT)
//   even_parity  : XOR reduction of a data word (zero-extended to MAX_W)
//   frame_len    : number of serial bits per frame for a given word width
// Optional feature macro: SR_PISO_PARITY_EN (appends one even-parity bit).
package sr_piso_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Zero-extension does not change the XOR, so callers may pass narrow words.
  function automatic logic even_parity(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

  function automatic int frame_len(input int w);
`ifdef SR_PISO_PARITY_EN
    return w + 1;
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/sr_piso_bitcnt.sv
// Loadable down-counter tracking the bits left in the current frame.
//   clk, rst : clock, async active-high reset
//   ld       : load ld_val (priority over decrement)
//   en       : decrement by one; saturates at zero
//   cnt      : current count
//   is_last  : count is one, i.e. the final frame bit is on the line
module sr_piso_bitcnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          en,
  input  logic [CW-1:0] ld_val,
  output logic [CW-1:0] cnt,
  output logic          is_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (ld)                   cnt <= ld_val;
    else if (en && (cnt != '0))    cnt <= cnt - 1'b1;
  end

  assign is_last = (cnt == CW'(1));

endmodule

// File: rtl/sr_piso_serializer.sv
// Parallel-in / serial-out serializer with ready/valid framing.
//   clk, rst   : clock, async active-high reset
//   din, load  : parallel word and load request (accepted when ready)
//   ready      : a load is accepted on the next rising edge
//   sout       : serial data, sout_valid marks frame bits
//   last       : final bit of the frame (parity bit when enabled)
//   busy       : frame in progress
// Optional feature macro: SR_PISO_PARITY_EN appends an even-parity bit.
module sr_piso_serializer
  import sr_piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int FW = frame_len(WIDTH);
  localparam int CW = $clog2(WIDTH + 2);

  state_t         state;
  logic [FW-1:0]  shreg;
  logic [FW-1:0]  frame;
  logic [CW-1:0]  cnt;
  logic           cnt_last;
  logic           accept;
  logic           shifting;

  // Frame image laid out so the first bit sits at the shift-out end.
  always_comb begin
`ifdef SR_PISO_PARITY_EN
    frame = MSB_FIRST ? {din, even_parity(MAX_W'(din))}
                      : {even_parity(MAX_W'(din)), din};
`else
    frame = din;
`endif
  end

  assign shifting   = (state == SHIFT);
  // rst gates ready directly so it drops asynchronously even though the
  // FSM already sits in IDLE during reset.
  assign ready      = ~rst & (~shifting | cnt_last);
  assign accept     = load & ready;
  assign sout_valid = shifting;
  assign busy       = shifting;
  assign last       = shifting & cnt_last;
  assign sout       = shifting & (MSB_FIRST ? shreg[FW-1] : shreg[0]);

  sr_piso_bitcnt #(.CW(CW)) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .ld      (accept),
    .en      (shifting),
    .ld_val  (CW'(FW)),
    .cnt     (cnt),
    .is_last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg <= frame;
          state <= SHIFT;
        end
        SHIFT: begin
          if (cnt_last) begin
            // load during the last bit chains the next frame with no gap
            if (load) shreg <= frame;
            else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sr_piso_serializer.md
SR_PISO_SERIALIZER -- requirements
Module: sr_piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 = LSB shifted first, 1 = MSB shifted first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, WIDTH bits: parallel data word.
REQ-006 SHALL have port load, input, 1 bit: load request; qualifies din.
REQ-007 SHALL have port ready, output, 1 bit: block accepts load this cycle.
REQ-008 SHALL have port sout, output, 1 bit: serial data out.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit.
REQ-010 SHALL have port last, output, 1 bit: sout carries the final bit of the frame.
REQ-011 SHALL have port busy, output, 1 bit: frame in progress.

Function
REQ-012 SHALL implement the two-state FSM IDLE and SHIFT.
REQ-013 SHALL drive ready = 1 in IDLE, and in SHIFT only during the cycle where last = 1; ready SHALL be 0 otherwise.
REQ-014 SHALL, on a rising edge with load & ready, capture din into the shift register, load the bit counter with the frame length N, and enter SHIFT.
REQ-015 SHALL present the first frame bit on sout, with sout_valid = 1, in the cycle immediately after the accepting edge (latency 1).
REQ-016 SHALL shift exactly one bit per clock, taking bit 0 first when MSB_FIRST = 0 and bit WIDTH-1 first when MSB_FIRST = 1.
REQ-017 SHALL assert last coincident with bit N of the frame.
REQ-018 SHALL, when load = 1 during the last-bit cycle, start the next frame back-to-back with no idle cycle.
REQ-019 SHALL otherwise return to IDLE after the last bit.
REQ-020 SHALL ignore load (no capture, no state change) while ready = 0; a din change mid-frame SHALL NOT affect sout.
REQ-021 SHALL hold sout = 0, sout_valid = 0, last = 0, busy = 0 in IDLE.
REQ-022 SHALL drive busy = 1 throughout SHIFT.
REQ-023 SHALL size the bit counter as $clog2(WIDTH+2) bits; the counter SHALL NOT wrap past zero.

Reset
REQ-024 SHALL, while rst = 1, force the FSM to IDLE, clear the shift register and counter, and drive sout, sout_valid, last, busy and ready to 0, asynchronously.
REQ-025 SHALL abort a frame in progress when rst is asserted mid-frame; no remaining bits are emitted after rst deasserts.
REQ-026 SHALL drive ready = 1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL support the macro SR_PISO_PARITY_EN.
- Defined: append one even-parity bit (XOR of captured din) after the data bits; N = WIDTH+1; last is asserted on the parity bit.
- Undefined: no parity bit; N = WIDTH.

Structure
REQ-028 SHALL place the following in package sr_piso_pkg:
- state typedef (IDLE, SHIFT);
- even-parity function;
- frame-length constant helper.
REQ-029 SHALL implement the bit counter as sub-module sr_piso_bitcnt: loadable down-counter with a last-flag output.

Verification
REQ-030 WIDTH=4, MSB_FIRST=0, rst pulse, then load=1 with din=4'b0101 -> sout 1,0,1,0 in cycles 1..4; last on cycle 4; busy in cycles 1..4; ready=0 in cycles 1..3.
REQ-031 WIDTH=4, MSB_FIRST=1, din=4'b0111 -> sout 0,1,1,1; then IDLE with sout=0.
REQ-032 load held high with din=4'b0101 then 4'b0111 (switched in the last-bit cycle) -> 8 contiguous valid bits 1,0,1,0,1,1,1,0 with no gap; last pulses on bits 4 and 8.
REQ-033 rst asserted after bit 2 of a frame -> sout, sout_valid, busy = 0 immediately; no remaining bits are emitted; ready=1 after release.
REQ-034 load=1 with din changed mid-frame while ready=0 -> frame unaffected; no extra frame is started.
REQ-035 SR_PISO_PARITY_EN defined, WIDTH=4, din=4'b0111 -> sout 1,1,1,0,1; last on bit 5.
